if_id_fifo: RTL and testbench
=============================

// Module: if_id_fifo
// PURPOSE
//  Parametrised IF->ID boundary register: DEPTH-entry FIFO with valid/ready
//  handshake, multi-lane fetch packets (LANES instr per PC) and flush.
//  Replaces the single-entry stall-vector IF/ID latch. IF-side backpressure
//  comes from in_ready, so a fetch accepted during an ID stall is held, not lost.
//  Sits between the fetch/AXI instruction path and the decode stage.
// PARAMETERS
//  ADDR_W  32  width of the packet PC
//  DATA_W  32  width of one instruction
//  LANES   1   instructions per fetch packet (1..4)
//  DEPTH   2   buffer entries; power of 2, >=2
// PORTS
//  clk          in   1              rising-edge clock
//  rst          in   1              synchronous reset, active-high
//  flush        in   1              discard all buffered and incoming packets
//  in_valid     in   1              IF presents a packet
//  in_ready     out  1              buffer can accept (= !full)
//  in_pc        in   ADDR_W         PC of lane 0
//  in_inst      in   LANES*DATA_W   lane i at [i*DATA_W +: DATA_W]
//  in_lane_vld  in   LANES          per-lane valid mask
//  out_valid    out  1              head entry present (= !empty)
//  out_ready    in   1              ID consumes head this cycle
//  out_pc       out  ADDR_W         head PC; 0 when empty
//  out_inst     out  LANES*DATA_W   head instructions; 0 (NOP) when empty
//  out_lane_vld out  LANES          head lane mask; 0 when empty
//  count        out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  - push = in_valid & in_ready & !flush; pop = out_valid & out_ready & !flush.
//  - Storage: DEPTH-entry RAM, wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrap mod DEPTH.
//  - count: +1 on push only, -1 on pop only, unchanged on push&pop.
//  - in_ready and out_valid derive combinationally from registered count only.
//    No combinational in->out path.
//  - Latency: a packet pushed in cycle N is visible at out_* in cycle N+1.
//  - Full (count==DEPTH): in_ready=0; a simultaneous pop does not enable a push
//    that cycle.
//  - Empty: out_valid=0; out_pc/out_inst/out_lane_vld forced to 0 (bubble = NOP).
//    out_ready is ignored.
//  - Flush: next cycle count=0, wr_ptr=rd_ptr=0, out_valid=0, outputs 0.
//    An in_valid in the flush cycle is dropped.
//  - Reset (any cycle, incl. mid-stream): identical to flush. All outputs read 0
//    next cycle, except in_ready=1. RAM contents are not cleared.
//  - rst has priority over flush; flush has priority over push/pop.
//  - Output data is held stable while out_valid & !out_ready.
//  - Entries with in_lane_vld==0 are still stored; filtering is ID's job.
// CONFIGURATION
//  IF_ID_EXC_EN defined:
//    - Adds in_exc (in, 5) and out_exc (out, 5): fetch exception code (e.g.
//      ADEL=5'h04), stored per entry and returned with the head. 0 when empty.
//    - A nonzero out_exc forces out_inst to 0 for every lane.
//  IF_ID_EXC_EN undefined:
//    - in_exc/out_exc ports and their storage are absent; behaviour otherwise
//      identical.
// TESTING
//  1 rst=1 for 2 clk -> in_ready=1, out_valid=0, count=0, out_pc=0, out_inst=0.
//  2 Push pc=0xBFC00000, inst=0x24080001; out_ready=1 ->
//    next clk out_valid=1, out_pc=0xBFC00000, then empty.
//  3 out_ready=0, push 3 packets (DEPTH=2) -> first two accepted, count=2,
//    in_ready=0; third held by IF. Release out_ready -> FIFO order pc0, pc1, pc2.
//  4 count=1, simultaneous push+pop over 8 cycles with wrap -> count stays 1,
//    in-order data, no loss.
//  5 count=2 plus in_valid, assert flush -> next clk count=0, out_valid=0;
//    the flushed packet never appears.
//  6 IF_ID_EXC_EN: push in_exc=5'h04, inst=0x8C020000 -> out_exc=5'h04,
//    out_inst=0. Without macro the same push yields out_inst=0x8C020000.

Source files
------------

// File: rtl/if_id_fifo.sv
// ============================================================================
// if_id_fifo : IF->ID boundary FIFO carrying multi-lane fetch packets, with
//              valid/ready handshake and flush. Optional macro IF_ID_EXC_EN
//              adds a per-entry fetch exception code (in_exc/out_exc).
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_fifo #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LANES  = 1,
  parameter int DEPTH  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ADDR_W-1:0]             in_pc,
  input  logic [LANES*DATA_W-1:0]       in_inst,
  input  logic [LANES-1:0]              in_lane_vld,
`ifdef IF_ID_EXC_EN
  input  logic [4:0]                    in_exc,
  output logic [4:0]                    out_exc,
`endif
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ADDR_W-1:0]             out_pc,
  output logic [LANES*DATA_W-1:0]       out_inst,
  output logic [LANES-1:0]              out_lane_vld,
  output logic [$clog2(DEPTH):0]        count
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

  logic [ADDR_W-1:0]       r_pc_mem   [DEPTH];
  logic [LANES*DATA_W-1:0] r_inst_mem [DEPTH];
  logic [LANES-1:0]        r_vld_mem  [DEPTH];

  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;

  logic w_push;
  logic w_pop;
  logic w_head_exc_zero;

  // Handshake flags come only from registered occupancy: no in->out comb path.
  assign in_ready  = (r_count != c_full);
  assign out_valid = (r_count != '0);
  assign count     = r_count;

  assign w_push = in_valid & in_ready & ~flush;
  assign w_pop  = out_valid & out_ready & ~flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is intentionally not reset; occupancy alone defines what is live.
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_pc_mem[r_wr_ptr]   <= in_pc;
      r_inst_mem[r_wr_ptr] <= in_inst;
      r_vld_mem[r_wr_ptr]  <= in_lane_vld;
    end
  end

`ifdef IF_ID_EXC_EN
  logic [4:0] r_exc_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_exc_mem[r_wr_ptr] <= in_exc;
    end
  end

  assign w_head_exc_zero = (r_exc_mem[r_rd_ptr] == 5'd0);
  assign out_exc         = out_valid ? r_exc_mem[r_rd_ptr] : 5'd0;
`else
  assign w_head_exc_zero = 1'b1;
`endif

  // Empty FIFO presents a NOP bubble; a faulting fetch never exposes its data.
  always_comb begin
    out_pc       = '0;
    out_inst     = '0;
    out_lane_vld = '0;
    if (out_valid) begin
      out_pc       = r_pc_mem[r_rd_ptr];
      out_lane_vld = r_vld_mem[r_rd_ptr];
      if (w_head_exc_zero) begin
        out_inst = r_inst_mem[r_rd_ptr];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_id_fifo.sv
// ============================================================================
// tb_if_id_fifo : directed plus randomized self-checking bench for if_id_fifo
//                 against a queue-based packet model.
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_id_fifo;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LANES  = 2;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic                    clk = 1'b0;
  logic                    rst, flush, in_valid, out_ready;
  logic                    in_ready, out_valid;
  logic [ADDR_W-1:0]       in_pc, out_pc;
  logic [LANES*DATA_W-1:0] in_inst, out_inst;
  logic [LANES-1:0]        in_lane_vld, out_lane_vld;
  logic [CNT_W-1:0]        count;
  logic [4:0]              exc_drv;
`ifdef IF_ID_EXC_EN
  logic [4:0]              out_exc;
`endif

  always #5 clk = ~clk;

  if_id_fifo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .in_lane_vld(in_lane_vld),
`ifdef IF_ID_EXC_EN
    .in_exc(exc_drv), .out_exc(out_exc),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .out_lane_vld(out_lane_vld), .count(count)
  );

  typedef struct {
    logic [ADDR_W-1:0]       pc;
    logic [LANES*DATA_W-1:0] inst;
    logic [LANES-1:0]        vld;
    logic [4:0]              exc;
  } ent_t;

  ent_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_en = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
    end
  endtask

  // Packet-level model: a bounded queue; pushes see the occupancy before the pop.
  task automatic model_step();
    bit   do_push, do_pop;
    ent_t e;
    if (rst || flush) begin
      q.delete();
    end else begin
      do_push = in_valid && (q.size() < DEPTH);
      do_pop  = out_ready && (q.size() > 0);
      e.pc   = in_pc;
      e.inst = in_inst;
      e.vld  = in_lane_vld;
`ifdef IF_ID_EXC_EN
      e.exc  = exc_drv;
`else
      e.exc  = 5'd0;
`endif
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [ADDR_W-1:0]       e_pc;
      logic [LANES*DATA_W-1:0] e_inst;
      logic [LANES-1:0]        e_vld;
      logic [4:0]              e_exc;
      e_pc = '0; e_inst = '0; e_vld = '0; e_exc = '0;
      if (q.size() > 0) begin
        e_pc  = q[0].pc;
        e_vld = q[0].vld;
        e_exc = q[0].exc;
        e_inst = (q[0].exc != 5'd0) ? '0 : q[0].inst;
      end
      chk("m_in_ready",  128'(in_ready),  128'(q.size() < DEPTH));
      chk("m_out_valid", 128'(out_valid), 128'(q.size() > 0));
      chk("m_count",     128'(count),     128'(q.size()));
      chk("m_out_pc",    128'(out_pc),    128'(e_pc));
      chk("m_out_inst",  128'(out_inst),  128'(e_inst));
      chk("m_out_vld",   128'(out_lane_vld), 128'(e_vld));
`ifdef IF_ID_EXC_EN
      chk("m_out_exc",   128'(out_exc),   128'(e_exc));
`endif
    end
  end

  task automatic drive(input logic v, input logic [ADDR_W-1:0] pc, input logic [DATA_W-1:0] i0);
    in_valid    = v;
    in_pc       = pc;
    in_inst     = {32'h1111_0000 ^ i0, i0};
    in_lane_vld = 2'b01;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; exc_drv = 5'd0;
    drive(1'b0, '0, '0);

    // Reset for two cycles
    tick();
    chk_en = 1;
    tick();
    chk("rst_in_ready",  128'(in_ready),  128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_count",     128'(count),     128'(0));
    chk("rst_out_pc",    128'(out_pc),    128'(0));
    chk("rst_out_inst",  128'(out_inst),  128'(0));
    rst = 1'b0;

    // Single packet, one-cycle latency
    out_ready = 1'b1;
    drive(1'b1, 32'hBFC0_0000, 32'h2408_0001);
    tick();
    drive(1'b0, '0, '0);
    chk("lat_out_valid", 128'(out_valid),      128'(1));
    chk("lat_out_pc",    128'(out_pc),         128'(32'hBFC0_0000));
    chk("lat_inst0",     128'(out_inst[31:0]), 128'(32'h2408_0001));
    tick();
    chk("lat_empty",     128'(out_valid),      128'(0));

    // Fill to DEPTH under stall, third packet held by IF
    out_ready = 1'b0;
    drive(1'b1, 32'h100, 32'hA0);
    tick();
    drive(1'b1, 32'h104, 32'hA1);
    tick();
    drive(1'b1, 32'h108, 32'hA2);
    tick();
    chk("full_count",    128'(count),    128'(2));
    chk("full_in_ready", 128'(in_ready), 128'(0));
    chk("full_head",     128'(out_pc),   128'(32'h100));
    out_ready = 1'b1;
    tick();
    chk("order_pc1",     128'(out_pc),   128'(32'h104));
    chk("order_cnt1",    128'(count),    128'(1));
    tick();
    chk("order_pc2",     128'(out_pc),   128'(32'h108));
    drive(1'b0, '0, '0);
    tick();

    // Steady-state push+pop at count=1 with pointer wrap
    out_ready = 1'b0;
    drive(1'b1, 32'h200, 32'hB0);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h204 + 32'(4 * i), 32'hB1 + 32'(i));
      tick();
      chk("pp_count", 128'(count),  128'(1));
      chk("pp_pc",    128'(out_pc), 128'(32'h204 + 32'(4 * i)));
    end
    drive(1'b0, '0, '0);
    tick();

    // Flush while full with a pending in_valid
    out_ready = 1'b0;
    drive(1'b1, 32'h300, 32'hC0);
    tick();
    drive(1'b1, 32'h304, 32'hC1);
    tick();
    drive(1'b1, 32'h3FC, 32'hCF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    chk("flush_count", 128'(count),     128'(0));
    chk("flush_valid", 128'(out_valid), 128'(0));
    chk("flush_pc",    128'(out_pc),    128'(0));
    out_ready = 1'b1;
    tick();
    chk("flush_stays_empty", 128'(out_valid), 128'(0));

    // Exception-tagged fetch
    out_ready = 1'b0;
    exc_drv = 5'h04;
    drive(1'b1, 32'h400, 32'h8C02_0000);
    tick();
    exc_drv = 5'd0;
    drive(1'b0, '0, '0);
`ifdef IF_ID_EXC_EN
    chk("exc_code", 128'(out_exc),  128'(5'h04));
    chk("exc_inst", 128'(out_inst), 128'(0));
`else
    chk("noexc_inst", 128'(out_inst[31:0]), 128'(32'h8C02_0000));
`endif

    // Mid-stream reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_count",    128'(count),    128'(0));
    chk("mrst_in_ready", 128'(in_ready), 128'(1));

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst         = ($urandom_range(0, 99) == 0);
      flush       = ($urandom_range(0, 39) == 0);
      in_valid    = $urandom_range(0, 1);
      out_ready   = ($urandom_range(0, 3) != 0);
      in_pc       = $urandom;
      in_inst     = {$urandom, $urandom};
      in_lane_vld = LANES'($urandom);
      exc_drv     = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
      tick();
    end

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    tick();
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
